// File: rtl/uart_rx_dual_if.sv
// Bundle for uart_rx_dual: serial line in, per-class byte/valid strobes and error/status out.
// master = receiver side, slave = line driver / byte consumer.
interface uart_rx_dual_if #(
    parameter int DATA_W = 8
);
    logic              rx;
    logic              cmd_valid;
    logic [DATA_W-1:0] cmd_data;
    logic              pic_valid;
    logic [DATA_W-1:0] pic_data;
    logic              mode_pic;
    logic              frame_err;
    logic              parity_err;
    logic              busy;

    modport master (
        input  rx,
        output cmd_valid, cmd_data, pic_valid, pic_data,
        output mode_pic, frame_err, parity_err, busy
    );

    modport slave (
        output rx,
        input  cmd_valid, cmd_data, pic_valid, pic_data,
        input  mode_pic, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_dual.sv
// Dual-rate UART rx: frame is command if the line is high at the command stop point, else picture.
// Strobes land one cycle after the stop sample, no backpressure; UART_RX_PARITY_EN adds an even-parity bit.
module uart_rx_dual #(
    parameter int DATA_W      = 8,
    parameter int CMD_DIV     = 52,
    parameter int PIC_DIV     = 1250,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clock_system,
    input  logic           rstn,
    uart_rx_dual_if.master bus
);
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int SH_W     = DATA_W + PAR_BITS;
    localparam int STOP_IDX = DATA_W + 1 + PAR_BITS;
    localparam int CNT_W    = $clog2(PIC_DIV * (DATA_W + 3));

    localparam logic [CNT_W-1:0] T_GLITCH = CNT_W'(CMD_DIV / 2);
    localparam logic [CNT_W-1:0] T_DET    = CNT_W'(CMD_DIV * STOP_IDX + CMD_DIV / 2);
    localparam logic [CNT_W-1:0] T_PSTOP  = CNT_W'(PIC_DIV * STOP_IDX + PIC_DIV / 2);

    typedef enum logic [1:0] {IDLE, RUN_CMD, RUN_PIC} state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_prev_q;
    logic                   rxs;
    logic                   fall;
    logic [SH_W-1:0]        cmd_sh_q;
    logic [SH_W-1:0]        pic_sh_q;
    logic                   cmd_valid_q;
    logic                   pic_valid_q;
    logic                   frame_err_q;
    logic                   mode_pic_q;
    logic [DATA_W-1:0]      cmd_data_q;
    logic [DATA_W-1:0]      pic_data_q;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err_q;
`endif

    // True at the centre of any data (or parity) bit for the given bit period.
    function automatic logic at_data_pt(input logic [CNT_W-1:0] c, input int div);
        logic hit;
        hit = 1'b0;
        for (int k = 1; k <= SH_W; k++) begin
            hit = hit | (c == CNT_W'(div * k + div / 2));
        end
        return hit;
    endfunction

    assign rxs   = sync_q[SYNC_STAGES-1];
    assign fall  = rxs_prev_q & ~rxs;
    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clock_system or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sync_q       <= '1;
            rxs_prev_q   <= 1'b1;
            cmd_sh_q     <= '0;
            pic_sh_q     <= '0;
            cmd_valid_q  <= 1'b0;
            pic_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            mode_pic_q   <= 1'b0;
            cmd_data_q   <= '0;
            pic_data_q   <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.rx};
            rxs_prev_q   <= rxs;
            cmd_valid_q  <= 1'b0;
            pic_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= RUN_CMD;
                        cnt_q   <= '0;
                    end
                end
                RUN_CMD: begin
                    cnt_q <= cnt_d;
                    // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
                    if (at_data_pt(cnt_q, CMD_DIV)) begin
                        cmd_sh_q <= {rxs, cmd_sh_q[SH_W-1:1]};
                    end
                    if (cnt_q == T_GLITCH && rxs) begin
                        state_q <= IDLE;
                    end else if (cnt_q == T_DET) begin
                        if (rxs) begin
                            state_q     <= IDLE;
                            cmd_valid_q <= 1'b1;
                            cmd_data_q  <= cmd_sh_q[DATA_W-1:0];
                            mode_pic_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= ^cmd_sh_q;
`endif
                        end else begin
                            // Start bit still held: this is a slow picture frame, keep counting.
                            state_q <= RUN_PIC;
                        end
                    end
                end
                RUN_PIC: begin
                    cnt_q <= cnt_d;
                    if (at_data_pt(cnt_q, PIC_DIV)) begin
                        pic_sh_q <= {rxs, pic_sh_q[SH_W-1:1]};
                    end
                    if (cnt_q == T_PSTOP) begin
                        state_q <= IDLE;
                        if (rxs) begin
                            pic_valid_q <= 1'b1;
                            pic_data_q  <= pic_sh_q[DATA_W-1:0];
                            mode_pic_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= ^pic_sh_q;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_data   = cmd_data_q;
    assign bus.pic_valid  = pic_valid_q;
    assign bus.pic_data   = pic_data_q;
    assign bus.mode_pic   = mode_pic_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_dual.sv
// Bench for uart_rx_dual: directed vector table, hand-written corner sequences, random frames
// checked against a frame-level model (frame kind + stop level decide which strobe fires).
`timescale 1ns/1ps
module tb_uart_rx_dual;
    localparam int DATA_W      = 8;
    localparam int CMD_DIV     = 52;
    localparam int PIC_DIV     = 1250;
    localparam int SYNC_STAGES = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int T_DET   = CMD_DIV * (DATA_W + 1 + PAR) + CMD_DIV / 2;
    localparam int T_PSTOP = PIC_DIV * (DATA_W + 1 + PAR) + PIC_DIV / 2;
    // rx pin edge to cnt=0 takes SYNC_STAGES+1 cycles, the strobe one more after the sample cycle.
    localparam int LAT0    = SYNC_STAGES + 2;

    typedef struct {
        bit                pic;
        logic [DATA_W-1:0] d;
        bit                stop;
        bit                flip;
        int                e_cmd;
        int                e_pic;
        int                e_ferr;
        int                e_perr;
        logic [DATA_W-1:0] e_cmd_dat;
        logic [DATA_W-1:0] e_pic_dat;
        bit                e_mode;
    } vec_t;

    logic clock_system = 1'b0;
    logic rstn = 1'b1;

    uart_rx_dual_if #(.DATA_W(DATA_W)) bus ();

    uart_rx_dual #(
        .DATA_W(DATA_W), .CMD_DIV(CMD_DIV), .PIC_DIV(PIC_DIV), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clock_system(clock_system),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clock_system = ~clock_system;

    int cyc = 0;
    int n_cmd = 0, n_pic = 0, n_ferr = 0, n_perr = 0;
    int cmd_cyc = 0, pic_cyc = 0;
    int n_tests = 0, n_fail = 0;

    always @(posedge clock_system) cyc <= cyc + 1;

    always @(negedge clock_system) begin
        if (bus.cmd_valid === 1'b1) begin
            n_cmd   <= n_cmd + 1;
            cmd_cyc <= cyc;
        end
        if (bus.pic_valid === 1'b1) begin
            n_pic   <= n_pic + 1;
            pic_cyc <= cyc;
        end
        if (bus.frame_err === 1'b1) n_ferr <= n_ferr + 1;
        if (bus.parity_err === 1'b1) n_perr <= n_perr + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock_system);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input bit pic, input logic [DATA_W-1:0] d, input bit stop,
                              input bit flip, output int start);
        int div;
        bit q[$];
        div = pic ? PIC_DIV : CMD_DIV;
        q.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) q.push_back(d[i]);
        if (PAR == 1) q.push_back((^d) ^ flip);
        q.push_back(stop);
        start = cyc;
        foreach (q[i]) begin
            bus.rx = q[i];
            tick(div);
        end
        bus.rx = 1'b1;
    endtask

    task automatic do_frame(input vec_t v, input string name);
        int b_cmd, b_pic, b_ferr, b_perr, start;
        b_cmd = n_cmd; b_pic = n_pic; b_ferr = n_ferr; b_perr = n_perr;
        send_frame(v.pic, v.d, v.stop, v.flip, start);
        tick(4);
        check($sformatf("%s cmd_valid pulses", name), n_cmd - b_cmd, v.e_cmd);
        check($sformatf("%s pic_valid pulses", name), n_pic - b_pic, v.e_pic);
        check($sformatf("%s frame_err pulses", name), n_ferr - b_ferr, v.e_ferr);
        check($sformatf("%s parity_err pulses", name), n_perr - b_perr, v.e_perr);
        check($sformatf("%s cmd_data", name), bus.cmd_data, v.e_cmd_dat);
        check($sformatf("%s pic_data", name), bus.pic_data, v.e_pic_dat);
        check($sformatf("%s mode_pic", name), bus.mode_pic, v.e_mode);
        if (v.e_cmd == 1) check($sformatf("%s cmd latency", name), cmd_cyc - start, LAT0 + T_DET);
        if (v.e_pic == 1) check($sformatf("%s pic latency", name), pic_cyc - start, LAT0 + T_PSTOP);
    endtask

    vec_t tbl[6];
    vec_t v;
    logic [DATA_W-1:0] m_cmd, m_pic;
    bit m_mode;

    initial begin
        int b_cmd, b_pic, b_ferr, b_perr, st;

        tbl[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1, 0, 0, 0, 8'hA5, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'h3C, 1'b1, 1'b0, 0, 1, 0, 0, 8'hA5, 8'h3C, 1'b1};
        tbl[2] = '{1'b1, 8'h81, 1'b0, 1'b0, 0, 0, 1, 0, 8'hA5, 8'h3C, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 0, 0, 0, 8'h00, 8'h3C, 1'b0};
        tbl[4] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1, 0, 0, 0, 8'hFF, 8'h3C, 1'b0};
        tbl[5] = '{1'b0, 8'h07, 1'b1, (PAR == 1), 1, 0, 0, PAR, 8'h07, 8'h3C, 1'b0};

        bus.rx = 1'b1;
        #1 rstn = 1'b0;
        tick(3);
        check("reset cmd_valid", bus.cmd_valid, 0);
        check("reset pic_valid", bus.pic_valid, 0);
        check("reset cmd_data", bus.cmd_data, 0);
        check("reset pic_data", bus.pic_data, 0);
        check("reset mode_pic", bus.mode_pic, 0);
        check("reset frame_err", bus.frame_err, 0);
        check("reset parity_err", bus.parity_err, 0);
        check("reset busy", bus.busy, 0);
        rstn = 1'b1;
        tick(3);

        for (int i = 0; i < 6; i++) do_frame(tbl[i], $sformatf("vec%0d", i));
        m_cmd = tbl[5].e_cmd_dat; m_pic = tbl[5].e_pic_dat; m_mode = tbl[5].e_mode;

        // Short low pulse on an idle line must be dropped as a start glitch.
        b_cmd = n_cmd; b_pic = n_pic; b_ferr = n_ferr; b_perr = n_perr;
        bus.rx = 1'b0;
        tick(10);
        check("glitch busy during", bus.busy, 1);
        bus.rx = 1'b1;
        tick(22);
        check("glitch busy released", bus.busy, 0);
        check("glitch no strobes", (n_cmd - b_cmd) + (n_pic - b_pic) + (n_ferr - b_ferr) + (n_perr - b_perr), 0);
        check("glitch cmd_data held", bus.cmd_data, m_cmd);

        // Three commands with no idle gap beyond the single stop bit.
        b_cmd = n_cmd; b_perr = n_perr;
        send_frame(1'b0, 8'h01, 1'b1, 1'b0, st);
        send_frame(1'b0, 8'h02, 1'b1, 1'b0, st);
        send_frame(1'b0, 8'h03, 1'b1, 1'b0, st);
        tick(4);
        check("b2b cmd_valid pulses", n_cmd - b_cmd, 3);
        check("b2b parity_err pulses", n_perr - b_perr, 0);
        check("b2b cmd_data", bus.cmd_data, 8'h03);
        m_cmd = 8'h03; m_mode = 1'b0;

        // Reset in the middle of a picture frame, then a fresh command.
        b_cmd = n_cmd; b_pic = n_pic; b_ferr = n_ferr; b_perr = n_perr;
        bus.rx = 1'b0;
        tick(SYNC_STAGES + 1 + 3000);
        check("midreset busy before", bus.busy, 1);
        rstn = 1'b0;
        bus.rx = 1'b1;
        #1;
        check("midreset busy", bus.busy, 0);
        check("midreset cmd_data", bus.cmd_data, 0);
        check("midreset pic_data", bus.pic_data, 0);
        check("midreset mode_pic", bus.mode_pic, 0);
        tick(5);
        rstn = 1'b1;
        tick(5);
        check("midreset no strobes", (n_cmd - b_cmd) + (n_pic - b_pic) + (n_ferr - b_ferr) + (n_perr - b_perr), 0);
        m_cmd = '0; m_pic = '0; m_mode = 1'b0;
        v = '{1'b0, 8'h5A, 1'b1, 1'b0, 1, 0, 0, 0, 8'h5A, 8'h00, 1'b0};
        do_frame(v, "after_reset 5A");
        m_cmd = 8'h5A;

        // Random frames against the frame-level model.
        for (int i = 0; i < 16; i++) begin
            v.pic  = (i == 7);
            v.d    = DATA_W'($urandom);
            v.stop = v.pic ? ($urandom_range(0, 3) != 0) : 1'b1;
            v.flip = (PAR == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            v.e_cmd  = !v.pic ? 1 : 0;
            v.e_pic  = (v.pic && v.stop) ? 1 : 0;
            v.e_ferr = (v.pic && !v.stop) ? 1 : 0;
            v.e_perr = (v.flip && (!v.pic || v.stop)) ? 1 : 0;
            if (!v.pic) begin
                m_cmd = v.d; m_mode = 1'b0;
            end else if (v.stop) begin
                m_pic = v.d; m_mode = 1'b1;
            end
            v.e_cmd_dat = m_cmd;
            v.e_pic_dat = m_pic;
            v.e_mode    = m_mode;
            do_frame(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_dual.md
# uart_rx_dual

Parametrised dual-rate UART receiver for the FPGA command/picture link. It auto-classifies each incoming frame as a fast command frame (CMD_DIV clocks/bit) or a slow picture frame (PIC_DIV clocks/bit) from the line level at the command stop-bit midpoint. It delivers the byte on the matching channel with a one-cycle valid pulse. It adds configurable width, divisors, a synchroniser, start-glitch rejection, framing-error reporting and optional parity checking.

## Interface
- DATA_W, 8: data bits per frame, LSB first, range 5..9.
- CMD_DIV, 52: clock_system cycles per command bit, minimum 8.
- PIC_DIV, 1250: cycles per picture bit. Legal only if PIC_DIV > CMD_DIV*(DATA_W+3).
- SYNC_STAGES, 2: rx synchroniser flops, minimum 2.

Ports:
- clock_system  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, idle high.
- cmd_valid  out  1  one-cycle pulse; cmd_data holds a new command byte.
- cmd_data  out  DATA_W  last accepted command byte.
- pic_valid  out  1  one-cycle pulse; pic_data holds a new picture byte.
- pic_data  out  DATA_W  last accepted picture byte.
- mode_pic  out  1  class of last accepted frame (1 = picture).
- frame_err  out  1  one-cycle pulse; picture stop bit sampled low.
- parity_err  out  1  one-cycle pulse; parity mismatch (see Configuration).
- busy  out  1  high while a frame is in progress.

## Operation
- rx passes through SYNC_STAGES flops, giving rxs. A falling edge on rxs in IDLE loads counter cnt=0 and enters RUN_CMD.
- cnt increments every cycle in RUN_CMD and RUN_PIC. Its width is clog2(PIC_DIV*(DATA_W+3)). It never wraps.
- Sample point for bit index k (start=0, data k=1..DATA_W, then parity if enabled, then stop) is DIV*k + DIV/2, using integer division.
- RUN_CMD:
  - At CMD_DIV/2, rxs high means a glitch: return to IDLE with no output.
  - Command data bits are sampled into a shadow register.
  - At the command stop point T_DET, rxs high classifies the frame as command. rxs low means the start bit is still held, so the frame is picture and the state moves to RUN_PIC with cnt continuing.
- RUN_PIC: picture data bits are sampled into a second shadow register. At the picture stop point, rxs high accepts the frame; rxs low pulses frame_err.
- On accept, the shadow register is copied to cmd_data or pic_data, the matching valid pulses, and mode_pic is updated. The FSM returns to IDLE.
- Command frames cannot raise frame_err because a low stop is classified as picture.
- cmd_data, pic_data and mode_pic hold their values until the next accepted frame. A rejected or errored frame changes none of them.
- FSM states: IDLE, RUN_CMD, RUN_PIC. All exits return to IDLE. A falling edge during RUN_* is ignored.
- busy = (state != IDLE).

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0, synchroniser flops 1.
- Reset mid-frame clears everything immediately with no pulse. After release, the FSM needs a fresh falling edge.
- The edge-to-cnt=0 delay is fixed: SYNC_STAGES+1 cycles from the rx pin.
- valid/error pulses are asserted the cycle after the stop sample cycle. Data and mode_pic update in that same cycle.
- A new frame may start on the cycle after the FSM returns to IDLE. Back-to-back frames with a one-bit stop are received without loss.
- With defaults (DATA_W=8, no parity), T_DET=494 and the picture stop point is 11875.

## Configuration
- UART_RX_PARITY_EN defined: one even-parity bit follows the data, and stop shifts one bit later. T_DET becomes CMD_DIV*(DATA_W+2)+CMD_DIV/2. A mismatch still delivers the byte with its valid pulse and pulses parity_err in the same cycle. If a picture frame has both a parity mismatch and a low stop, only frame_err pulses.
- Not defined: frames carry no parity bit, and parity_err is tied to 0.

## Test plan
- Command 0xA5 at 52 clocks/bit, stop high: cmd_valid pulses once with cmd_data=0xA5 and mode_pic=0. No pic_valid.
- Picture 0x3C at 1250 clocks/bit: pic_valid pulses once with pic_data=0x3C and mode_pic=1. No cmd_valid.
- rx low for 10 cycles, then high: no pulse, and busy returns low before cycle 30 after the edge.
- Picture 0x81 with stop low: frame_err pulses, while pic_data, mode_pic and pic_valid are unchanged.
- Reset asserted at cnt=3000 in a picture frame, then command 0x5A sent: only cmd_valid pulses, with cmd_data=0x5A.
- With UART_RX_PARITY_EN, command 0x07 with parity 0: cmd_valid and parity_err pulse together, cmd_data=0x07. Three back-to-back commands 0x01/0x02/0x03 then give three cmd_valid pulses.
